uart_tx_mmio: RTL

- Memory-mapped UART transmitter that acts as a responder on the core's data-memory bus (we/addr/data_i/data_o), alongside the data memory.
- The core stores bytes into a small TX FIFO. A serializer FSM shifts them out on `tx` as 8N1 frames.
- Status and baud divisor are readable and writable by loads and stores.
- Top-level mux selects `data_o` from this block when `sel` is high.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_tx_mmio_if.sv | 14 +
 rtl/sync_fifo.sv | 59 +++++
 rtl/uart_tx_mmio.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter block (and a later RX block).
// Contents: serializer state enum, register offset constants (addr[3:2]),
// STATUS bit positions and an even-parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic [1:0] TXDATA_OFF  = 2'd0;
  localparam logic [1:0] STATUS_OFF  = 2'd1;
  localparam logic [1:0] BAUDDIV_OFF = 2'd2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;
  localparam int STAT_PAR     = 9;

  // Even parity of one data byte: 1 when the byte has an odd number of ones.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// Data-memory bus seen by the UART transmitter.
// Signals: we (store strobe), addr (byte address), data_i (store data),
// data_o (load data), sel (address hits the register window).
// master = core side, slave = responder side.
interface uart_tx_mmio_if;
  logic        we;
  logic [31:0] addr;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        sel;

  modport master (output we, addr, data_i, input data_o, sel);
  modport slave  (input we, addr, data_i, output data_o, sel);
endinterface

// File: rtl/sync_fifo.sv
// Synchronous circular-buffer FIFO.
// Ports: clk, rst (sync, active high), push/din (write), pop/dout (read of
// head, dout is valid whenever empty=0), full, empty, count (0..DEPTH).
// A push while full is accepted only when a pop happens in the same cycle.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == {CW{1'b0}});
  assign count   = count_q;
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= {AW{1'b0}};
      rd_ptr  <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter on the core's data-memory bus.
// Ports: clk, rst (sync, active high), bus (uart_tx_mmio_if.slave:
// we/addr/data_i in, data_o/sel out), tx (serial line, idles high).
// Registers (addr[3:2]): 0 TXDATA (write pushes byte), 1 STATUS,
// 2 BAUDDIV (clk cycles per bit, 0 behaves as 1), 3 reserved.
// Build option: define UART_TX_PARITY_EN for an even-parity bit between
// the data and stop bits (STATUS bit9 then reads 1).
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter logic [15:0] CLK_DIV    = 16'd868,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_mmio_if.slave   bus,
  output logic            tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          sel;
  logic [1:0]    off;
  logic          wr_en;
  logic          push;
  logic          pop;
  logic [7:0]    fifo_dout;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [15:0]   baud;
  logic          ovf;
  logic [15:0]   reload;
  logic          bit_done;
  logic [31:0]   status;
  logic [31:0]   rdata;
  logic          unused_bits;

  uart_state_e   state, state_next;
  logic [15:0]   cnt, cnt_next;
  logic [2:0]    bit_idx, bit_next;
  logic [7:0]    shift, shift_next;
  logic          tx_q, tx_next;
`ifdef UART_TX_PARITY_EN
  logic          par;
`endif

  assign sel         = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign off         = bus.addr[3:2];
  assign wr_en       = bus.we && sel;
  assign push        = wr_en && (off == TXDATA_OFF);
  assign unused_bits = ^{bus.addr[1:0], bus.data_i[31:16]};
  // Period counter counts down to zero, so it is loaded with period-1.
  assign reload      = (baud == 16'd0) ? 16'd0 : (baud - 16'd1);
  assign bit_done    = (cnt == 16'd0);
  assign tx          = tx_q;
  assign bus.sel     = sel;
  assign bus.data_o  = rdata;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (bus.data_i[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // BAUDDIV register and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud <= CLK_DIV;
      ovf  <= 1'b0;
    end else begin
      if (wr_en && (off == BAUDDIV_OFF)) baud <= bus.data_i[15:0];
      // A dropped byte and a clear cannot coincide: they use different offsets.
      if (push && full && !pop) begin
        ovf <= 1'b1;
      end else if (wr_en && (off == STATUS_OFF) && bus.data_i[STAT_OVF]) begin
        ovf <= 1'b0;
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is captured at pop because the shift register is consumed bit by bit.
  always_ff @(posedge clk) begin
    if (rst)      par <= 1'b0;
    else if (pop) par <= even_parity(fifo_dout);
  end
`endif

  // Serializer state register; tx is registered so the line is glitch free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 16'd0;
      bit_idx <= 3'd0;
      shift   <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_next;
      shift   <= shift_next;
      tx_q    <= tx_next;
    end
  end

  // Serializer next state: each bit boundary reloads the period from the
  // current BAUDDIV, so a mid-frame write only affects later bits.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    bit_next   = bit_idx;
    shift_next = shift;
    tx_next    = tx_q;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          shift_next = fifo_dout;
          bit_next   = 3'd0;
          cnt_next   = reload;
          tx_next    = 1'b0;
          state_next = START;
        end else begin
          tx_next = 1'b1;
        end
      end
      START: begin
        if (bit_done) begin
          cnt_next   = reload;
          tx_next    = shift[0];
          state_next = DATA;
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_next = reload;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_next    = par;
            state_next = PARITY;
`else
            tx_next    = 1'b1;
            state_next = STOP;
`endif
          end else begin
            bit_next   = bit_idx + 3'd1;
            shift_next = {1'b0, shift[7:1]};
            tx_next    = shift[1];
          end
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end
      PARITY: begin
        if (bit_done) begin
          cnt_next   = reload;
          tx_next    = 1'b1;
          state_next = STOP;
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end
      STOP: begin
        if (bit_done) begin
          tx_next    = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end
      default: begin
        tx_next    = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  // Load data mux: combinational from addr, zero outside the window.
  always_comb begin
    status                           = 32'd0;
    status[STAT_BUSY]                = (state != IDLE);
    status[STAT_FULL]                = full;
    status[STAT_EMPTY]               = empty;
    status[STAT_OVF]                 = ovf;
    status[STAT_CNT_LSB +: CW]       = count;
`ifdef UART_TX_PARITY_EN
    status[STAT_PAR]                 = 1'b1;
`else
    status[STAT_PAR]                 = 1'b0;
`endif
    rdata = 32'd0;
    if (sel) begin
      case (off)
        STATUS_OFF:  rdata = status;
        BAUDDIV_OFF: rdata = {16'd0, baud};
        default:     rdata = 32'd0;
      endcase
    end else begin
      rdata = 32'd0;
    end
  end

endmodule
